// File: rtl/ifetch_queue.sv
// Instruction fetch queue: issues in-order fetch requests under a credit limit,
// tags responses with their PC, and buffers them for decode with redirect flush.
module ifetch_queue #(
  parameter int D_WIDTH = 32,
  parameter int DEPTH   = 4
) (
  input  logic               CLK,
  input  logic               rst,
  input  logic [D_WIDTH-1:0] PC,
  input  logic               PCsrc,
  output logic               pc_advance,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [D_WIDTH-1:0] imem_addr,
  input  logic               imem_rsp_valid,
  input  logic [D_WIDTH-1:0] imem_rsp_data,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [D_WIDTH-1:0] instr,
  output logic [D_WIDTH-1:0] instr_pc,
  output logic               misalign_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW:0] DEPTH_S = (PW+1)'(DEPTH);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [PW-1:0] outst_q, outst_d;
  logic [PW-1:0] tag_wp_q, tag_rp_q;
  logic [PW-1:0] fifo_wp_q, fifo_rp_q;
  logic [PW-1:0] occ;

  logic [D_WIDTH-1:0] tag_mem       [DEPTH];
  logic [D_WIDTH-1:0] fifo_data_mem [DEPTH];
  logic [D_WIDTH-1:0] fifo_pc_mem   [DEPTH];

  logic in_run;
  logic credit_ok;
  logic rsp_take;
  logic rsp_keep;
  logic pop;
  logic misalign_now;

  assign imem_addr    = PC;
  assign in_run       = (state_q == ST_RUN);
  assign occ          = fifo_wp_q - fifo_rp_q;
  assign credit_ok    = ({1'b0, outst_q} + {1'b0, occ}) < DEPTH_S;
  assign misalign_now = in_run && !PCsrc && (PC[1:0] != 2'b00);

  // rst gates the request so nothing is offered while reset is held
  assign imem_req_valid = rst && in_run && !PCsrc && (PC[1:0] == 2'b00)
                          && !misalign_err && credit_ok;
  assign pc_advance     = imem_req_valid && imem_req_ready;

  // A response with nothing outstanding is stray and never touches state
  assign rsp_take = imem_rsp_valid && (outst_q != '0);
  assign rsp_keep = rsp_take && in_run && !PCsrc;

  assign instr_valid = (fifo_wp_q != fifo_rp_q);
  assign pop         = instr_valid && instr_ready;
  assign instr       = instr_valid ? fifo_data_mem[fifo_rp_q[AW-1:0]] : '0;
  assign instr_pc    = instr_valid ? fifo_pc_mem[fifo_rp_q[AW-1:0]]   : '0;

  // The outstanding count doubles as the drop count while draining
  always_comb begin
    outst_d = outst_q;
    if (pc_advance) outst_d = outst_d + PW'(1);
    if (rsp_take)   outst_d = outst_d - PW'(1);
  end

  always_comb begin
    state_d = state_q;
    if (PCsrc) begin
      state_d = (outst_d != '0) ? ST_DRAIN : ST_RUN;
    end else if (state_q == ST_DRAIN && outst_d == '0) begin
      state_d = ST_RUN;
    end
  end

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_RUN;
      outst_q      <= '0;
      tag_wp_q     <= '0;
      tag_rp_q     <= '0;
      fifo_wp_q    <= '0;
      fifo_rp_q    <= '0;
      misalign_err <= 1'b0;
    end else begin
      state_q <= state_d;
      outst_q <= outst_d;
      if (misalign_now) misalign_err <= 1'b1;
      if (PCsrc) begin
        tag_wp_q  <= '0;
        tag_rp_q  <= '0;
        fifo_wp_q <= '0;
        fifo_rp_q <= '0;
      end else begin
        if (pc_advance) tag_wp_q  <= tag_wp_q + PW'(1);
        if (rsp_keep)   tag_rp_q  <= tag_rp_q + PW'(1);
        if (rsp_keep)   fifo_wp_q <= fifo_wp_q + PW'(1);
        if (pop)        fifo_rp_q <= fifo_rp_q + PW'(1);
      end
    end
  end

  // Storage arrays carry no reset; validity comes from the pointers
  always_ff @(posedge CLK) begin
    if (pc_advance) tag_mem[tag_wp_q[AW-1:0]] <= PC;
    if (rsp_keep) begin
      fifo_data_mem[fifo_wp_q[AW-1:0]] <= imem_rsp_data;
      fifo_pc_mem[fifo_wp_q[AW-1:0]]   <= tag_mem[tag_rp_q[AW-1:0]];
    end
  end

endmodule

// File: doc/ifetch_queue.md
IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 SHALL have parameter D_WIDTH, default 32, the address/instruction width.
REQ-002 SHALL have parameter DEPTH, default 4, the instruction buffer entries (power of two, 2..16).
REQ-003 SHALL have port CLK, input, 1, the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1, reset: asynchronous assert, active-low (0 = reset).
REQ-005 SHALL have port PC, input, D_WIDTH, the current fetch address from the PC register.
REQ-006 SHALL have port PCsrc, input, 1, redirect taken this cycle; flushes in-flight fetches.
REQ-007 SHALL have port pc_advance, output, 1, pulses for each cycle a request for PC is accepted.
REQ-008 SHALL have port imem_req_valid, output, 1, fetch request valid.
REQ-009 SHALL have port imem_req_ready, input, 1, memory accepts the request.
REQ-010 SHALL have port imem_addr, output, D_WIDTH, the request address.
REQ-011 SHALL have port imem_rsp_valid, input, 1, in-order instruction response valid.
REQ-012 SHALL have port imem_rsp_data, input, D_WIDTH, the response instruction word.
REQ-013 SHALL have port instr_valid, output, 1, buffer head valid to decode.
REQ-014 SHALL have port instr_ready, input, 1, decode consumes the head.
REQ-015 SHALL have port instr, output, D_WIDTH, the head instruction.
REQ-016 SHALL have port instr_pc, output, D_WIDTH, the address of the head instruction.
REQ-017 SHALL have port misalign_err, output, 1, sticky flag set when PC[1:0] != 0.

Function
REQ-018 SHALL drive imem_addr = PC combinationally.
REQ-019 SHALL assert imem_req_valid only in RUN, with PCsrc=0, PC[1:0]=0, misalign_err=0, and outstanding+occupancy < DEPTH.
REQ-020 SHALL assert pc_advance = imem_req_valid & imem_req_ready; this is the only request handshake.
REQ-021 SHALL push the accepted PC into a DEPTH-entry tag queue and increment outstanding (0..DEPTH).
REQ-022 SHALL, in RUN, write each response (data, popped tag) into the instruction FIFO and decrement outstanding.
REQ-023 SHALL present the FIFO head registered: instr_valid rises no earlier than the cycle after the response is captured, with no bypass.
REQ-024 SHALL pop the head on instr_valid & instr_ready and hold instr/instr_pc stable while instr_valid=1 and instr_ready=0.
REQ-025 SHALL allow push and pop in the same cycle at any occupancy; the credit rule of REQ-019 prevents overflow.
REQ-026 SHALL wrap FIFO and tag-queue pointers modulo DEPTH, with full/empty distinguished by an extra pointer bit.
REQ-027 SHALL implement the FSM RUN -> DRAIN on PCsrc=1 when outstanding (after this cycle's response) > 0, and RUN -> RUN on PCsrc=1 when it is 0.
REQ-028 SHALL, on PCsrc=1, in the same edge clear FIFO and tag queue, deassert instr_valid next cycle, and issue no request that cycle.
REQ-029 SHALL, in DRAIN, discard each response, decrement the drop count, and issue no requests.
REQ-030 SHALL go DRAIN -> RUN when the drop count reaches 0.
REQ-031 SHALL restart the DRAIN count from the current outstanding on a PCsrc=1 received in DRAIN.
REQ-032 SHALL discard a response coinciding with PCsrc=1 in RUN, excluding it from the drop count.
REQ-033 SHALL ignore imem_rsp_valid when outstanding=0 and leave all state unchanged.
REQ-034 SHALL set misalign_err when PC[1:0] != 0 while in RUN with PCsrc=0; only reset clears it.

Reset
REQ-035 SHALL, while rst=0, force FSM=RUN, pointers/outstanding/drop count=0, instr_valid=0, imem_req_valid=0, pc_advance=0, misalign_err=0, and instr/instr_pc=0.
REQ-036 SHALL, on reset asserted mid-operation, discard all in-flight state; responses after deassertion fall under REQ-033.
REQ-037 SHALL first assert imem_req_valid in the first cycle after rst deasserts, if REQ-019 holds.

Verification
REQ-038 Bench SHALL cover: PC=0x0, ready=1, 1-cycle memory returning 0x00500093 -> instr_valid next cycle after response, instr=0x00500093, instr_pc=0x0.
REQ-039 Bench SHALL cover: instr_ready=0, DEPTH=4, 4 requests accepted -> imem_req_valid=0 until a pop, no entry lost, order preserved.
REQ-040 Bench SHALL cover: 3 outstanding, PCsrc=1 at PC=0x40 -> FSM DRAIN, 3 responses dropped, next request addr 0x40, instr_valid=0 throughout.
REQ-041 Bench SHALL cover: PCsrc=1 during DRAIN with 1 outstanding -> drop count reloaded, no stale instruction delivered.
REQ-042 Bench SHALL cover: PC=0x6 -> misalign_err=1 sticky, no request; rst=0 -> misalign_err=0.
REQ-043 Bench SHALL cover: rst=0 pulsed with 2 buffered, 2 outstanding -> all outputs at reset values immediately, late responses ignored.
